// File: rtl/fifo_rd_unpack.sv
// Unpacks wide FIFO words into narrow valid/ready beats, least-significant slice
// first, through a 2-entry prefetch buffer fed by a registered-read FIFO.
module fifo_rd_unpack #(
   parameter int IN_WIDTH  = 64,
   parameter int OUT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 fifo_empty,
   output logic                 fifo_pop,
   input  logic [IN_WIDTH-1:0]  fifo_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_last,
   output logic                 busy
);
   localparam int RATIO     = IN_WIDTH / OUT_WIDTH;
   localparam int IDX_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(RATIO - 1);
   localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);

   logic [IN_WIDTH-1:0]  buf_r [2];
   logic [1:0]           buf_cnt_r;
   logic                 wr_ptr_r;
   logic                 rd_ptr_r;
   logic                 inflight_r;
   logic [IDX_WIDTH-1:0] slice_idx_r;

   logic                 valid_s;
   logic                 at_last_s;
   logic                 xfer_s;
   logic                 deq_s;
   logic [2:0]           occ_s;
   logic [IN_WIDTH-1:0]  head_s;

   // Handshake decode, pop request and beat selection from the head word
   always_comb begin
      valid_s   = (buf_cnt_r != 2'd0);
      at_last_s = (slice_idx_r == LAST_IDX);
      xfer_s    = valid_s & out_ready;
      deq_s     = xfer_s & at_last_s;
      // occupancy next cycle, counting a word already in flight from the FIFO
      occ_s     = {1'b0, buf_cnt_r} + {2'b00, inflight_r} - {2'b00, deq_s};
      head_s    = buf_r[rd_ptr_r];
      fifo_pop  = ~rst & ~flush & ~fifo_empty & (occ_s < 3'd2);
      busy      = valid_s | inflight_r;
      out_valid = valid_s;
      if (valid_s) begin
         out_data = head_s[int'(slice_idx_r) * OUT_WIDTH +: OUT_WIDTH];
         out_last = at_last_s;
      end else begin
         out_data = {OUT_WIDTH{1'b0}};
         out_last = 1'b0;
      end
   end

   // Prefetch buffer, pointers, slice index and in-flight tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_r[0]    <= {IN_WIDTH{1'b0}};
         buf_r[1]    <= {IN_WIDTH{1'b0}};
         buf_cnt_r   <= 2'd0;
         wr_ptr_r    <= 1'b0;
         rd_ptr_r    <= 1'b0;
         inflight_r  <= 1'b0;
         slice_idx_r <= {IDX_WIDTH{1'b0}};
      end else if (flush) begin
         buf_cnt_r   <= 2'd0;
         wr_ptr_r    <= 1'b0;
         rd_ptr_r    <= 1'b0;
         inflight_r  <= 1'b0;
         slice_idx_r <= {IDX_WIDTH{1'b0}};
      end else begin
         inflight_r <= fifo_pop;
         if (inflight_r) begin
            buf_r[wr_ptr_r] <= fifo_data;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (xfer_s) begin
            if (at_last_s) begin
               slice_idx_r <= {IDX_WIDTH{1'b0}};
               rd_ptr_r    <= ~rd_ptr_r;
            end else begin
               slice_idx_r <= slice_idx_r + IDX_ONE;
            end
         end
         buf_cnt_r <= buf_cnt_r + {1'b0, inflight_r} - {1'b0, deq_s};
      end
   end
endmodule

// File: tb/tb_fifo_rd_unpack.sv
// Directed bench for fifo_rd_unpack: RATIO=4 and RATIO=1 instances, each fed by
// a behavioural registered-read FIFO model.
module tb_fifo_rd_unpack;
   logic clk = 1'b0;
   logic rst;
   logic flush;

   logic        fifo_empty4, fifo_pop4, out_valid4, rdy4, out_last4, busy4;
   logic [63:0] fifo_data4 = 64'd0;
   logic [15:0] out_data4;
   logic        fifo_empty1, fifo_pop1, out_valid1, rdy1, out_last1, busy1;
   logic [63:0] fifo_data1 = 64'd0;
   logic [63:0] out_data1;

   logic [63:0] mem4 [0:511];
   logic [63:0] mem1 [0:15];
   logic [8:0]  wr4 = 9'd0;
   logic [8:0]  rd4 = 9'd0;
   logic [3:0]  wr1 = 4'd0;
   logic [3:0]  rd1 = 4'd0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_rd_unpack #(.IN_WIDTH(64), .OUT_WIDTH(16)) dut4 (
      .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty4),
      .fifo_pop(fifo_pop4), .fifo_data(fifo_data4), .out_valid(out_valid4),
      .out_ready(rdy4), .out_data(out_data4), .out_last(out_last4), .busy(busy4));

   fifo_rd_unpack #(.IN_WIDTH(64), .OUT_WIDTH(64)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty1),
      .fifo_pop(fifo_pop1), .fifo_data(fifo_data1), .out_valid(out_valid1),
      .out_ready(rdy1), .out_data(out_data1), .out_last(out_last1), .busy(busy1));

   // Registered-read FIFO models: data appears the cycle after an accepted pop
   assign fifo_empty4 = (wr4 == rd4);
   assign fifo_empty1 = (wr1 == rd1);
   always @(posedge clk) begin
      if (fifo_pop4 && !fifo_empty4) begin
         fifo_data4 <= mem4[rd4];
         rd4        <= rd4 + 9'd1;
      end
      if (fifo_pop1 && !fifo_empty1) begin
         fifo_data1 <= mem1[rd1];
         rd1        <= rd1 + 4'd1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push4(input logic [63:0] w);
      mem4[wr4] = w;
      wr4 = wr4 + 9'd1;
   endtask

   task automatic push1(input logic [63:0] w);
      mem1[wr1] = w;
      wr1 = wr1 + 4'd1;
   endtask

   function automatic logic [15:0] sl(input logic [63:0] w, input int s);
      return w[s*16 +: 16];
   endfunction

   task automatic beat4(input string tag, input logic [15:0] d, input logic l);
      chk({tag, "_valid"}, 64'(out_valid4), 64'd1);
      chk({tag, "_data"},  64'(out_data4),  64'(d));
      chk({tag, "_last"},  64'(out_last4),  64'(l));
      chk({tag, "_nopop_empty"}, 64'(fifo_pop4 & fifo_empty4), 64'd0);
   endtask

   task automatic idle4(input string tag);
      chk({tag, "_valid"}, 64'(out_valid4), 64'd0);
      chk({tag, "_data"},  64'(out_data4),  64'd0);
      chk({tag, "_last"},  64'(out_last4),  64'd0);
      chk({tag, "_busy"},  64'(busy4),      64'd0);
   endtask

   logic [63:0] w;
   logic [63:0] bw [3];
   logic [63:0] words1 [8];
   logic [63:0] sb [$];
   int beats;
   int cyc;

   initial begin
      rst = 1'b1; flush = 1'b0; rdy4 = 1'b0; rdy1 = 1'b1;
      #2;
      // Reset state, and no pop request while reset is held even with data waiting
      idle4("rst4");
      chk("rst1_valid", 64'(out_valid1), 64'd0);
      chk("rst1_busy",  64'(busy1),      64'd0);
      push4(64'h4444_3333_2222_1111);
      #1;
      chk("rst_pop_gated", 64'(fifo_pop4), 64'd0);

      // Single word, RATIO=4
      @(negedge clk); rst = 1'b0; rdy4 = 1'b1; #1;
      chk("s1_pop_t", 64'(fifo_pop4), 64'd1);
      chk("s1_valid_t", 64'(out_valid4), 64'd0);
      @(negedge clk); #1;
      chk("s1_pop_t1", 64'(fifo_pop4), 64'd0);
      chk("s1_busy_t1", 64'(busy4), 64'd1);
      chk("s1_valid_t1", 64'(out_valid4), 64'd0);
      @(negedge clk); #1; beat4("s1_b0", 16'h1111, 1'b0);
      @(negedge clk); #1; beat4("s1_b1", 16'h2222, 1'b0);
      @(negedge clk); #1; beat4("s1_b2", 16'h3333, 1'b0);
      @(negedge clk); #1; beat4("s1_b3", 16'h4444, 1'b1);
      @(negedge clk); #1; idle4("s1_end");

      // Back-to-back, RATIO=1: 8 beats in 8 consecutive cycles
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         words1[i] = {32'hC0DE_0000 + 32'(i), 32'h5A5A_1000 + 32'(i * 3)};
         push1(words1[i]);
      end
      #1;
      chk("r1_pop_t", 64'(fifo_pop1), 64'd1);
      @(negedge clk); #1;
      chk("r1_valid_t1", 64'(out_valid1), 64'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         chk("r1_valid", 64'(out_valid1), 64'd1);
         chk("r1_data",  out_data1, words1[i]);
         chk("r1_last",  64'(out_last1), 64'd1);
         chk("r1_nopop_empty", 64'(fifo_pop1 & fifo_empty1), 64'd0);
      end
      @(negedge clk); #1;
      chk("r1_end_valid", 64'(out_valid1), 64'd0);
      chk("r1_end_busy",  64'(busy1), 64'd0);

      // Backpressure: 3 words, ready low for 10 cycles once the first beat is valid
      @(negedge clk); rdy4 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bw[k] = {16'h0B03 + 16'(k * 16), 16'h0B02 + 16'(k * 16),
                  16'h0B01 + 16'(k * 16), 16'h0B00 + 16'(k * 16)};
         push4(bw[k]);
      end
      #1;
      chk("bp_pop_t", 64'(fifo_pop4), 64'd1);
      @(negedge clk); #1;
      chk("bp_pop_t1", 64'(fifo_pop4), 64'd1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); #1;
         beat4("bp_hold", 16'h0B00, 1'b0);
         chk("bp_hold_pop", 64'(fifo_pop4), 64'd0);
         if (k > 0) chk("bp_word_left", 64'(fifo_empty4), 64'd0);
      end
      for (int n = 0; n < 12; n++) begin
         @(negedge clk); rdy4 = 1'b1; #1;
         beat4("bp_rel", sl(bw[n / 4], n % 4), (n % 4) == 3);
      end
      @(negedge clk); #1; idle4("bp_end");

      // Flush with a pop in flight while the head word is at slice 2
      @(negedge clk); rdy4 = 1'b0; push4(64'hF003_F002_F001_F000); #1;
      chk("fl_pop_x", 64'(fifo_pop4), 64'd1);
      @(negedge clk); #1;
      @(negedge clk); rdy4 = 1'b1; #1; beat4("fl_x0", 16'hF000, 1'b0);
      @(negedge clk); #1; beat4("fl_x1", 16'hF001, 1'b0);
      @(negedge clk); rdy4 = 1'b0; push4(64'hEEEE_EEEE_EEEE_EEEE); #1;
      beat4("fl_x2", 16'hF002, 1'b0);
      chk("fl_pop_y", 64'(fifo_pop4), 64'd1);
      @(negedge clk); flush = 1'b1; #1;
      chk("fl_pop_during", 64'(fifo_pop4), 64'd0);
      beat4("fl_x2_hold", 16'hF002, 1'b0);
      @(negedge clk); flush = 1'b0; #1; idle4("fl_after");
      @(negedge clk); rdy4 = 1'b1; push4(64'hD003_D002_D001_D000); #1;
      chk("fl_pop_z", 64'(fifo_pop4), 64'd1);
      @(negedge clk); #1;
      for (int s = 0; s < 4; s++) begin
         @(negedge clk); #1; beat4("fl_z", 16'hD000 + 16'(s), s == 3);
      end
      @(negedge clk); #1; idle4("fl_end");

      // Async reset pulse between edges during beat 2 of a word
      @(negedge clk);
      push4(64'hA003_A002_A001_A000);
      push4(64'hB003_B002_B001_B000);
      push4(64'h9003_9002_9001_9000);
      #1;
      chk("ar_pop_v", 64'(fifo_pop4), 64'd1);
      @(negedge clk); #1;
      @(negedge clk); #1; beat4("ar_v0", 16'hA000, 1'b0);
      @(negedge clk); #1; beat4("ar_v1", 16'hA001, 1'b0);
      #1; rst = 1'b1; #1;
      idle4("ar_in_rst");
      chk("ar_pop_in_rst", 64'(fifo_pop4), 64'd0);
      rst = 1'b0; #1;
      chk("ar_pop_after", 64'(fifo_pop4), 64'd1);
      @(negedge clk); #1;
      chk("ar_valid_t1", 64'(out_valid4), 64'd0);
      chk("ar_busy_t1",  64'(busy4), 64'd1);
      for (int s = 0; s < 4; s++) begin
         @(negedge clk); #1; beat4("ar_u", 16'h9000 + 16'(s), s == 3);
      end
      @(negedge clk); #1; idle4("ar_end");

      // Random ready over 200 random words against a scoreboard
      @(negedge clk);
      for (int i = 0; i < 200; i++) begin
         w = {$urandom, $urandom};
         push4(w);
         sb.push_back(w);
      end
      beats = 0;
      cyc = 0;
      while (beats < 800 && cyc < 4000) begin
         @(negedge clk); rdy4 = 1'($urandom_range(0, 1)); #1;
         cyc++;
         chk("rnd_nopop_empty", 64'(fifo_pop4 & fifo_empty4), 64'd0);
         if (out_valid4 && rdy4) begin
            w = sb[0];
            chk("rnd_data", 64'(out_data4), 64'(sl(w, beats % 4)));
            chk("rnd_last", 64'(out_last4), 64'((beats % 4) == 3));
            if ((beats % 4) == 3) void'(sb.pop_front());
            beats++;
         end
      end
      chk("rnd_beat_count", 64'(beats), 64'd800);
      @(negedge clk); #1; idle4("rnd_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fifo_rd_unpack.md
Name: fifo_rd_unpack

Overview:
- Downstream consumer of the wide synchronous FIFO, which has registered read data valid one cycle after an accepted pop.
- Pops IN_WIDTH words, holds them in a 2-entry prefetch buffer, and emits them as RATIO narrower OUT_WIDTH beats on a valid/ready stream, least-significant slice first.
- Sits between the FIFO read port and the PE-array operand feeders.
- Sustains one output beat per cycle with no bubbles while the FIFO is non-empty.

Parameters:
- IN_WIDTH, 64, width of a FIFO word.
- OUT_WIDTH, 16, width of an output beat. IN_WIDTH must be an integer multiple of OUT_WIDTH; RATIO >= 1.
- RATIO, IN_WIDTH/OUT_WIDTH, derived: beats per word.
- IDX_WIDTH, max(1, clog2(RATIO)), derived: slice index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of buffer, slice index and in-flight pop.
- fifo_empty  in  1  FIFO empty flag.
- fifo_pop  out  1  pop request to the FIFO.
- fifo_data  in  IN_WIDTH  FIFO registered read data, valid the cycle after an accepted pop.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  OUT_WIDTH  current beat.
- out_last  out  1  beat is the last slice of its word.
- busy  out  1  buffer non-empty or pop in flight.

Behaviour:
- Reset (rst=1, async): buf_cnt=0, wr/rd slot pointers=0, slice_idx=0, inflight=0. Outputs fifo_pop=0, out_valid=0, out_data=0, out_last=0, busy=0.
- inflight register: set to fifo_pop & ~fifo_empty & ~flush at each edge, otherwise cleared. When inflight=1, fifo_data is written into buffer slot wr_ptr, wr_ptr toggles, and buf_cnt increments.
- Dequeue event deq = out_valid & out_ready & (slice_idx==RATIO-1).
- Pop rule (combinational): fifo_pop = ~flush & ~fifo_empty & ((buf_cnt + inflight - deq) < 2).
  - Never pop while the FIFO is empty.
  - The buffer never overflows.
- Output:
  - out_valid = (buf_cnt != 0).
  - out_data = head word bits [slice_idx*OUT_WIDTH +: OUT_WIDTH], or 0 when out_valid=0.
  - out_last = out_valid & (slice_idx==RATIO-1).
- Handshake: a beat transfers when out_valid & out_ready.
  - On transfer, slice_idx increments, or wraps to 0 on the last slice; on wrap, rd_ptr toggles and buf_cnt decrements.
  - With out_valid=1 and out_ready=0, out_data, out_last and slice_idx hold stable.
- Simultaneous capture and dequeue in one cycle: buf_cnt is unchanged and both pointers advance.
- Latency: FIFO non-empty at cycle t with buffer empty gives fifo_pop=1 at t, capture at t+1, out_valid=1 at t+2 (first beat can transfer at t+2).
- Throughput, RATIO=1: back-to-back words, one beat per cycle with out_ready held high.
- flush=1, taking priority over capture and dequeue:
  - Clears buf_cnt, both pointers, slice_idx and inflight; fifo_pop=0 that cycle.
  - Data arriving from a pop issued the previous cycle is discarded (inflight cleared).
  - out_valid=0 on the following cycle.
- busy = (buf_cnt != 0) | inflight.
- Mid-operation rst behaves as a flush but asynchronously; a partially emitted word is lost.

Test Plan:
- Single word, RATIO=4: preload FIFO with 64'h4444_3333_2222_1111, out_ready=1 -> fifo_pop one cycle; beats 16'h1111, 2222, 3333, 4444 on 4 consecutive cycles; out_last on 4'h4444 only; then busy=0.
- Back-to-back, RATIO=1 (OUT_WIDTH=64): 8 words preloaded, out_ready=1 -> 8 beats in 8 consecutive cycles starting 2 cycles after the first pop; no pop while fifo_empty=1.
- Backpressure: 3 words, RATIO=4, out_ready low for 10 cycles after the first beat is valid -> buf_cnt saturates at 2; fifo_pop=0 while full; out_data/slice_idx stable; releasing gives 12 beats in order, no loss or duplication.
- Random out_ready (50%) over 200 words with random data vs. scoreboard -> exact beat sequence, out_last every 4th beat, fifo_pop never asserted with fifo_empty=1.
- Flush with pop in flight: assert flush the cycle after fifo_pop with the buffer holding 1 word mid-slice (slice_idx=2) -> next cycle out_valid=0, busy=0; the in-flight word is dropped; the subsequent FIFO word emits starting at slice 0.
- Async reset mid-word: rst pulsed between clock edges during beat 2 -> all outputs 0 immediately; after release, normal operation resumes from the next FIFO word.
